// File: rtl/parallel_crc_framer_pkg.sv
// Shared definitions for the CRC framer: FSM states, CRC-16/CCITT constants
// and the byte-wide CRC step used by the engine and the pass-through path.
package parallel_crc_framer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_CRC_HI = 2'd2,
    ST_CRC_LO = 2'd3
  } state_t;

  localparam logic [15:0] CRC_INIT = 16'hFFFF;
  localparam logic [15:0] CRC_POLY = 16'h1021;

  // One CRC-16/CCITT step over a full byte, MSB first, no reflection.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc,
                                             input logic [7:0]  data);
    logic [15:0] c;
    c = crc ^ {data, 8'h00};
    for (int i = 0; i < 8; i++) begin
      if (c[15]) c = (c << 1) ^ CRC_POLY;
      else       c = c << 1;
    end
    return c;
  endfunction

endpackage

// File: rtl/parallel_crc_framer_if.sv
// Byte-stream bus of the framer: upstream s_* channel and downstream m_* channel.
// master = the source/sink surrounding the framer, slave = the framer itself.
interface parallel_crc_framer_if;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_last;
  logic       s_ready;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_last;
  logic       m_ready;

  modport master (
    output s_data, s_valid, s_last, m_ready,
    input  s_ready, m_data, m_valid, m_last
  );

  modport slave (
    input  s_data, s_valid, s_last, m_ready,
    output s_ready, m_data, m_valid, m_last
  );
endinterface

// File: rtl/crc16_ccitt_byte_engine.sv
// Registered CRC-16/CCITT accumulator, one byte per enabled cycle.
// init wins over enable so a frame's final byte and the reload can share an edge.
module crc16_ccitt_byte_engine
  import parallel_crc_framer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        init,
  input  logic [7:0]  data_in,
  output logic [15:0] crc_out
);

  logic [15:0] r_crc;

  // Accumulate accepted bytes; reload on reset or frame boundary/abort.
  always_ff @(posedge clk) begin
    if (reset || init) begin
      r_crc <= CRC_INIT;
    end else if (enable) begin
      r_crc <= crc16_byte(r_crc, data_in);
    end
  end

  assign crc_out = r_crc;

endmodule

// File: rtl/parallel_crc_framer.sv
// Byte-stream framer: forwards payload with one cycle of latency, computes
// CRC-16/CCITT on the fly and optionally appends it (high byte first).
module parallel_crc_framer
  import parallel_crc_framer_pkg::*;
#(
  parameter bit APPEND_CRC = 1'b1,
  parameter int MAX_LEN    = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  parallel_crc_framer_if.slave    bus,
  input  logic                    i_abort,
  output logic [15:0]             o_crc_value,
  output logic                    o_frame_done,
  output logic                    o_len_err
);

  localparam logic [16:0] MAX_LEN_W = 17'(MAX_LEN);

  state_t      r_state;
  logic [7:0]  r_m_data;
  logic        r_m_valid;
  logic        r_m_last;
  logic [15:0] r_crc_value;
  logic        r_frame_done;
  logic        r_len_err;
  logic [15:0] r_byte_cnt;

  logic        w_out_free;
  logic        w_in_phase;
  logic        w_s_ready;
  logic        w_accept;
  logic        w_crc_lo_load;
  logic        w_done_passthru;
  logic        w_crc_en;
  logic        w_crc_init;
  logic [15:0] w_crc;
  logic [16:0] w_cnt_inc;

  // Output register can take a new byte when empty or being drained now.
  assign w_out_free      = !r_m_valid || bus.m_ready;
  assign w_in_phase      = (r_state == ST_IDLE) || (r_state == ST_DATA);
  assign w_s_ready       = w_in_phase && w_out_free && !reset;
  assign w_accept        = bus.s_valid && w_s_ready;
  assign w_crc_lo_load   = (r_state == ST_CRC_LO) && w_out_free;
  assign w_done_passthru = w_accept && bus.s_last && (APPEND_CRC == 1'b0);

  // Abort discards the byte; any frame completion reloads the CRC at once.
  assign w_crc_en   = w_accept && !i_abort;
  assign w_crc_init = i_abort || w_crc_lo_load || w_done_passthru;

  // A byte accepted in IDLE is the first of a new frame.
  assign w_cnt_inc = (r_state == ST_IDLE) ? 17'd1 : ({1'b0, r_byte_cnt} + 17'd1);

  crc16_ccitt_byte_engine u_crc (
    .clk     (clk),
    .reset   (reset),
    .enable  (w_crc_en),
    .init    (w_crc_init),
    .data_in (bus.s_data),
    .crc_out (w_crc)
  );

  // Framing FSM, output register, byte counter and status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_m_data     <= 8'h00;
      r_m_valid    <= 1'b0;
      r_m_last     <= 1'b0;
      r_crc_value  <= CRC_INIT;
      r_frame_done <= 1'b0;
      r_len_err    <= 1'b0;
      r_byte_cnt   <= 16'd0;
    end else if (i_abort) begin
      // crc_value and len_err keep reporting the last completed frame.
      r_state      <= ST_IDLE;
      r_m_valid    <= 1'b0;
      r_m_last     <= 1'b0;
      r_frame_done <= 1'b0;
      r_byte_cnt   <= 16'd0;
    end else begin
      r_frame_done <= 1'b0;
      if (w_out_free) begin
        r_m_valid <= 1'b0;
        r_m_last  <= 1'b0;
      end
      case (r_state)
        ST_IDLE, ST_DATA: begin
          if (w_accept) begin
            r_m_data  <= bus.s_data;
            r_m_valid <= 1'b1;
            // First byte of a frame clears the flag; later bytes only set it.
            r_len_err <= (w_cnt_inc > MAX_LEN_W) || (r_len_err && (r_state == ST_DATA));
            if (bus.s_last) begin
              if (APPEND_CRC) begin
                r_m_last   <= 1'b0;
                r_byte_cnt <= w_cnt_inc[15:0];
                r_state    <= ST_CRC_HI;
              end else begin
                r_m_last     <= 1'b1;
                r_byte_cnt   <= 16'd0;
                r_crc_value  <= crc16_byte(w_crc, bus.s_data);
                r_frame_done <= 1'b1;
                r_state      <= ST_IDLE;
              end
            end else begin
              r_m_last   <= 1'b0;
              r_byte_cnt <= w_cnt_inc[15:0];
              r_state    <= ST_DATA;
            end
          end
        end
        ST_CRC_HI: begin
          if (w_out_free) begin
            r_m_data  <= w_crc[15:8];
            r_m_valid <= 1'b1;
            r_m_last  <= 1'b0;
            r_state   <= ST_CRC_LO;
          end
        end
        ST_CRC_LO: begin
          if (w_crc_lo_load) begin
            r_m_data     <= w_crc[7:0];
            r_m_valid    <= 1'b1;
            r_m_last     <= 1'b1;
            r_crc_value  <= w_crc;
            r_frame_done <= 1'b1;
            r_byte_cnt   <= 16'd0;
            r_state      <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.s_ready   = w_s_ready;
  assign bus.m_data    = r_m_data;
  assign bus.m_valid   = r_m_valid;
  assign bus.m_last    = r_m_last;
  assign o_crc_value   = r_crc_value;
  assign o_frame_done  = r_frame_done;
  assign o_len_err     = r_len_err;

endmodule

// File: tb/tb_parallel_crc_framer.sv
// Directed bench for parallel_crc_framer (APPEND_CRC=1, MAX_LEN=4).
module tb_parallel_crc_framer;

  logic        clk = 1'b0;
  logic        reset;
  logic        abort;
  logic [15:0] crc_value;
  logic        frame_done;
  logic        len_err;

  parallel_crc_framer_if bus ();

  parallel_crc_framer #(
    .APPEND_CRC (1'b1),
    .MAX_LEN    (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .i_abort      (abort),
    .o_crc_value  (crc_value),
    .o_frame_done (frame_done),
    .o_len_err    (len_err)
  );

  always #5 clk = ~clk;

  int          n_total = 0;
  int          n_bad   = 0;
  logic [8:0]  obs_q[$];
  logic [15:0] crc_q[$];
  logic [7:0]  g_bytes [5] = '{8'h00, 8'hE1, 8'hF0, 8'h00, 8'h00};

  // Record every byte handed downstream and every completed-frame CRC.
  always @(negedge clk) begin
    if (!reset && bus.m_valid && bus.m_ready) obs_q.push_back({bus.m_last, bus.m_data});
    if (frame_done) crc_q.push_back(crc_value);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    int n;
    n = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = l;
    @(negedge clk);
    while (!bus.s_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!bus.s_ready) chk("send_ready", 32'(bus.s_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic [7:0] d, input logic l);
    int n;
    logic [8:0] v;
    n = 0;
    while (obs_q.size() == 0 && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (obs_q.size() == 0) begin
      chk({tag, "_timeout"}, 32'(obs_q.size()), 32'd1);
    end else begin
      v = obs_q.pop_front();
      chk(tag, 32'(v[7:0]), 32'(d));
      chk({tag, "_last"}, 32'(v[8]), 32'(l));
    end
  endtask

  task automatic check_crc(input string tag, input logic [15:0] exp);
    int n;
    n = 0;
    while (crc_q.size() == 0 && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (crc_q.size() == 0) chk({tag, "_timeout"}, 32'(crc_q.size()), 32'd1);
    else                   chk(tag, 32'(crc_q.pop_front()), 32'(exp));
  endtask

  task automatic send_str9();
    for (int i = 0; i < 9; i++) send_byte(8'h31 + 8'(i), (i == 8));
  endtask

  task automatic expect_str9(input string tag);
    for (int i = 0; i < 9; i++) check_out({tag, "_pay"}, 8'h31 + 8'(i), 1'b0);
    check_out({tag, "_crc_hi"}, 8'h29, 1'b0);
    check_out({tag, "_crc_lo"}, 8'hB1, 1'b1);
  endtask

  task automatic expect_zero_frame(input string tag);
    check_out({tag, "_pay"}, 8'h00, 1'b0);
    check_out({tag, "_crc_hi"}, 8'hE1, 1'b0);
    check_out({tag, "_crc_lo"}, 8'hF0, 1'b1);
    check_crc({tag, "_crc"}, 16'hE1F0);
  endtask

  // Let the pipeline drain, then confirm no extra frame_done pulse occurred.
  task automatic settle(input string tag);
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_done_once"}, 32'(crc_q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    abort       = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;
    bus.s_last  = 1'b0;
    bus.m_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_ready", 32'(bus.s_ready), 32'd0);
    chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
    chk("rst_m_last", 32'(bus.m_last), 32'd0);
    chk("rst_m_data", 32'(bus.m_data), 32'h00);
    chk("rst_crc_value", 32'(crc_value), 32'hFFFF);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_len_err", 32'(len_err), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_s_ready", 32'(bus.s_ready), 32'd1);

    // "123456789" -> 0x29B1 appended; 9 bytes exceed MAX_LEN=4
    send_str9();
    expect_str9("a");
    check_crc("a_crc", 16'h29B1);
    chk("a_len_err", 32'(len_err), 32'd1);
    settle("a");

    // Single 0x00 byte -> 0xE1F0; first byte clears len_err
    send_byte(8'h00, 1'b1);
    chk("b_len_err_clr", 32'(len_err), 32'd0);
    expect_zero_frame("b");
    settle("b");

    // Stall downstream while 0x29 is presented
    send_str9();
    @(posedge clk);
    #1;
    bus.m_ready = 1'b0;
    chk("c_hold_first", 32'(bus.m_data), 32'h29);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk("c_hold_data", 32'(bus.m_data), 32'h29);
      chk("c_hold_valid", 32'(bus.m_valid), 32'd1);
      chk("c_hold_s_ready", 32'(bus.s_ready), 32'd0);
    end
    bus.m_ready = 1'b1;
    expect_str9("c");
    check_crc("c_crc", 16'h29B1);
    settle("c");

    // Back-to-back frames
    send_str9();
    send_byte(8'h00, 1'b1);
    expect_str9("d1");
    check_crc("d1_crc", 16'h29B1);
    expect_zero_frame("d2");
    settle("d");

    // Abort mid-frame: outputs drop, crc_value kept, CRC register reloaded
    send_byte(8'h31, 1'b0);
    send_byte(8'h32, 1'b0);
    send_byte(8'h33, 1'b0);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("e_m_valid", 32'(bus.m_valid), 32'd0);
    chk("e_crc_value", 32'(crc_value), 32'hE1F0);
    settle("e");
    obs_q.delete();
    send_byte(8'h00, 1'b1);
    expect_zero_frame("e2");
    settle("e2");

    // Reset after byte 4 of "123456789"
    for (int i = 0; i < 4; i++) send_byte(8'h31 + 8'(i), 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("f_m_valid", 32'(bus.m_valid), 32'd0);
    chk("f_s_ready", 32'(bus.s_ready), 32'd0);
    chk("f_crc_value", 32'(crc_value), 32'hFFFF);
    reset = 1'b0;
    obs_q.delete();
    crc_q.delete();
    send_byte(8'h00, 1'b1);
    expect_zero_frame("f");
    settle("f");

    // 5-byte frame with MAX_LEN=4; payload ends in its own CRC, so CRC is 0
    for (int i = 0; i < 5; i++) begin
      send_byte(g_bytes[i], (i == 4));
      if (i == 3) chk("g_len_err_4", 32'(len_err), 32'd0);
      if (i == 4) chk("g_len_err_5", 32'(len_err), 32'd1);
    end
    for (int i = 0; i < 5; i++) check_out("g_pay", g_bytes[i], 1'b0);
    check_out("g_crc_hi", 8'h00, 1'b0);
    check_out("g_crc_lo", 8'h00, 1'b1);
    check_crc("g_crc", 16'h0000);
    chk("g_len_err_sticky", 32'(len_err), 32'd1);
    settle("g");
    send_byte(8'h00, 1'b1);
    chk("g_len_err_clr", 32'(len_err), 32'd0);
    expect_zero_frame("g2");
    settle("g2");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/parallel_crc_framer.md
PARALLEL_CRC_FRAMER -- requirements
Module: parallel_crc_framer

Interface
REQ-001 Parameter APPEND_CRC, default 1: 1 appends two CRC bytes after each frame; 0 passes frames through unchanged and only reports the CRC.
REQ-002 Parameter MAX_LEN, default 1024: maximum payload bytes per frame before len_err is set.
REQ-003 clk  in  1  single clock; all logic on posedge clk.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 s_data  in  8  payload byte from the upstream source.
REQ-006 s_valid  in  1  s_data is valid.
REQ-007 s_last  in  1  s_data is the final payload byte of the frame.
REQ-008 s_ready  out  1  the framer accepts s_data this cycle.
REQ-009 m_data  out  8  output byte (payload or CRC).
REQ-010 m_valid  out  1  m_data is valid.
REQ-011 m_last  out  1  m_data is the final byte of the output frame.
REQ-012 m_ready  in  1  the downstream sink accepts m_data this cycle.
REQ-013 abort  in  1  discards the current frame and returns to IDLE.
REQ-014 crc_value  out  16  final CRC of the last completed frame.
REQ-015 frame_done  out  1  one-cycle pulse when a frame completes.
REQ-016 len_err  out  1  sticky; the current or last frame exceeded MAX_LEN.

Function
REQ-017 The CRC SHALL be CRC-16/CCITT: polynomial 0x1021, initial value 0xFFFF, no input or output reflection, no final XOR, one byte per cycle.
REQ-018 The FSM SHALL have states IDLE, DATA, CRC_HI and CRC_LO; IDLE goes to DATA on the first accepted byte.
REQ-019 An output register SHALL be free when m_valid=0 or m_ready=1.
REQ-020 In IDLE and DATA, s_ready SHALL equal "output register free".
REQ-021 In CRC_HI and CRC_LO, s_ready SHALL be 0.
REQ-022 An accepted byte (s_valid and s_ready) SHALL appear on m_data on the next cycle (1-cycle latency).
REQ-023 An accepted byte SHALL update the CRC register in the same edge.
REQ-024 When APPEND_CRC=1, accepting s_last SHALL move the FSM to CRC_HI with m_last=0 on that byte.
REQ-025 In CRC_HI, when the output register is free, the block SHALL load crc[15:8] and go to CRC_LO.
REQ-026 In CRC_LO, when the output register is free, the block SHALL load crc[7:0] with m_last=1 and go to IDLE.
REQ-027 When APPEND_CRC=0, accepting s_last SHALL return the FSM to IDLE with m_last=1 on that byte.
REQ-028 On frame completion (CRC_LO load, or s_last accepted when APPEND_CRC=0), crc_value SHALL latch the final CRC.
REQ-029 On frame completion, frame_done SHALL pulse for exactly one cycle.
REQ-030 On frame completion, the CRC register SHALL reload 0xFFFF in the same edge, so back-to-back frames need no idle cycle.
REQ-031 While m_valid=1 and m_ready=0, m_data, m_valid and m_last SHALL hold stable.
REQ-032 A 16-bit byte counter SHALL increment per accepted byte and clear on frame completion.
REQ-033 len_err SHALL set when an accepted byte would make the count exceed MAX_LEN.
REQ-034 len_err SHALL clear only on reset or on the first byte of the next frame; the payload is still forwarded.
REQ-035 abort SHALL force, at the next edge, state IDLE, m_valid=0, the CRC register to 0xFFFF and the counter to 0.
REQ-036 abort SHALL leave crc_value unchanged and SHALL have priority over every other event.
REQ-037 s_last on a single-byte frame SHALL be legal (IDLE to CRC_HI directly).

Reset
REQ-038 On reset, the FSM SHALL go to IDLE and m_valid, m_last, frame_done and len_err SHALL be 0.
REQ-039 On reset, m_data SHALL be 0x00, crc_value 0xFFFF, the CRC register 0xFFFF and the counter 0.
REQ-040 Reset SHALL override abort and all traffic, including mid-frame and mid-CRC-append.
REQ-041 s_ready SHALL be 0 during the reset cycle.

Structure
REQ-042 A shared package SHALL hold the FSM state enum, CRC_INIT=16'hFFFF and CRC_POLY=16'h1021.
REQ-043 The combinational/registered byte-wide CRC update SHALL be one sub-module, crc16_ccitt_byte_engine, with ports clk, reset, enable, init, data_in[7:0], crc_out[15:0].
REQ-044 The FSM, output register and counter SHALL reside in parallel_crc_framer.

Verification
REQ-045 Bench SHALL send the frame "123456789" (0x31..0x39) with m_ready=1 -> 9 payload bytes, then 0x29 and 0xB1 (m_last on 0xB1); crc_value=0x29B1; one frame_done pulse.
REQ-046 Bench SHALL send a single byte 0x00 with s_last -> output 0x00, 0xE1, 0xF0 with m_last on 0xF0; crc_value=0xE1F0.
REQ-047 Bench SHALL run the REQ-045 frame with m_ready=0 for 5 cycles while 0x29 is presented -> m_data held at 0x29, s_ready=0, no byte lost; 0xB1 follows.
REQ-048 Bench SHALL send "123456789" then immediately a 0x00 frame -> CRCs 0x29B1 then 0xE1F0, with no idle cycle required between frames.
REQ-049 Bench SHALL assert reset after byte 4 of "123456789" -> next cycle m_valid=0, s_ready=0; then on the 0x00 frame crc_value=0xE1F0.
REQ-050 Bench SHALL use MAX_LEN=4 and send 5 bytes -> len_err sets on the 5th byte, all 5 bytes plus the CRC are forwarded, and len_err clears on the next frame's first byte.
